// File: rtl/tri_feeder.sv
// Buffered triangle transmitter feeding the rasterizer input with halt back-pressure.
// Optional statistics counters are enabled by defining TRI_FEEDER_STATS_EN.
module tri_feeder #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]     in_tri_S,
  input  logic [COLORS-1:0][SIGFIG-1:0]              in_color_U,
  input  logic                                       in_valid_H,
  output logic                                       in_ready_H,
  input  logic                                       halt_RnnnnL,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]     tri_R10S,
  output logic [COLORS-1:0][SIGFIG-1:0]              color_R10U,
  output logic                                       validTri_R10H,
  output logic                                       idle_H,
  output logic [31:0]                                triCount_U,
  output logic [31:0]                                stallCount_U
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TRI_W = VERTS * AXIS * SIGFIG;
  localparam int COL_W = COLORS * SIGFIG;
  localparam int ENT_W = TRI_W + COL_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic accept;
  logic transfer;
  logic slot_free;
  logic fifo_empty;
  logic pop;
  logic bypass;
  logic push;
  logic [ENT_W-1:0] head;

  // Ready depends only on registered occupancy, never on halt.
  assign in_ready_H = (count < FULL_CNT);
  assign fifo_empty = (count == '0);
  assign idle_H     = fifo_empty && !validTri_R10H;

  assign accept    = in_valid_H && in_ready_H;
  assign transfer  = validTri_R10H && halt_RnnnnL;
  assign slot_free = !validTri_R10H || transfer;
  assign pop       = slot_free && !fifo_empty;
  assign bypass    = slot_free && fifo_empty && accept;
  assign push      = accept && !bypass;
  assign head      = mem[rd_ptr];

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_tri_S, in_color_U};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output register: FIFO head has priority, then bypass; a stalled entry just holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tri_R10S      <= '0;
      color_R10U    <= '0;
      validTri_R10H <= 1'b0;
    end else if (pop) begin
      tri_R10S      <= head[ENT_W-1:COL_W];
      color_R10U    <= head[COL_W-1:0];
      validTri_R10H <= 1'b1;
    end else if (bypass) begin
      tri_R10S      <= in_tri_S;
      color_R10U    <= in_color_U;
      validTri_R10H <= 1'b1;
    end else if (transfer) begin
      validTri_R10H <= 1'b0;
    end
  end

`ifdef TRI_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      triCount_U   <= '0;
      stallCount_U <= '0;
    end else begin
      if (transfer) begin
        triCount_U <= triCount_U + 32'd1;
      end
      if (validTri_R10H && !halt_RnnnnL) begin
        stallCount_U <= stallCount_U + 32'd1;
      end
    end
  end
`else
  assign triCount_U   = 32'd0;
  assign stallCount_U = 32'd0;
`endif

endmodule

// File: tb/tb_tri_feeder.sv
// Scoreboard bench for tri_feeder: stimulus pushes accepted triangles, a negedge monitor
// checks order, hold-while-halted, ready/idle occupancy rules and statistics counters.
module tb_tri_feeder;

  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int DEPTH  = 4;

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]          col_t;
  typedef struct packed {
    tri_t t;
    col_t c;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  tri_t        in_tri_S = '0;
  col_t        in_color_U = '0;
  logic        in_valid_H = 1'b0;
  logic        in_ready_H;
  logic        halt_RnnnnL = 1'b1;
  tri_t        tri_R10S;
  col_t        color_R10U;
  logic        validTri_R10H;
  logic        idle_H;
  logic [31:0] triCount_U;
  logic [31:0] stallCount_U;

  int   checks = 0;
  int   passes = 0;
  int   model_tri = 0;
  int   model_stall = 0;
  int   accepted = 0;
  logic pend = 1'b0;
  ent_t pend_e;
  ent_t sb[$];

  tri_feeder #(
    .SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS), .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_tri_S     (in_tri_S),
    .in_color_U   (in_color_U),
    .in_valid_H   (in_valid_H),
    .in_ready_H   (in_ready_H),
    .halt_RnnnnL  (halt_RnnnnL),
    .tri_R10S     (tri_R10S),
    .color_R10U   (color_R10U),
    .validTri_R10H(validTri_R10H),
    .idle_H       (idle_H),
    .triCount_U   (triCount_U),
    .stallCount_U (stallCount_U)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        e.t[v][a] = SIGFIG'($urandom);
    for (int c = 0; c < COLORS; c++)
      e.c[c] = SIGFIG'($urandom);
    return e;
  endfunction

  function automatic logic [31:0] exp_stat(input int n);
`ifdef TRI_FEEDER_STATS_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n - n);
`endif
  endfunction

  // One cycle of stimulus; acceptance is committed to the scoreboard just after its edge.
  task automatic apply_stimulus(input logic v, input logic h, input ent_t e);
    @(posedge clk);
    #1;
    if (pend) sb.push_back(pend_e);
    pend = 1'b0;
    in_valid_H  = v;
    halt_RnnnnL = h;
    in_tri_S    = e.t;
    in_color_U  = e.c;
    #3;
    if (in_valid_H && in_ready_H) begin
      pend   = 1'b1;
      pend_e = e;
      accepted++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_valid"}, 256'(validTri_R10H), 256'(1'b0));
    check_output({tag, "_tri"}, 256'(tri_R10S), 256'(0));
    check_output({tag, "_color"}, 256'(color_R10U), 256'(0));
    check_output({tag, "_ready"}, 256'(in_ready_H), 256'(1'b1));
    check_output({tag, "_idle"}, 256'(idle_H), 256'(1'b1));
    check_output({tag, "_tricnt"}, 256'(triCount_U), 256'(0));
    check_output({tag, "_stallcnt"}, 256'(stallCount_U), 256'(0));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && (sb.size() != 0 || pend); i++)
      apply_stimulus(1'b0, 1'b1, rand_ent());
    check_output({tag, "_drained"}, 256'(sb.size()), 256'(0));
  endtask

  // Monitor: occupancy = accepted minus transferred; output valid whenever anything is held.
  always @(negedge clk) begin
    int   occ;
    logic exp_valid;
    if (rst) begin
      occ       = sb.size();
      exp_valid = (occ > 0);
      check_output("valid", 256'(validTri_R10H), 256'(exp_valid));
      check_output("ready", 256'(in_ready_H), 256'((occ - (exp_valid ? 1 : 0)) < DEPTH));
      check_output("idle", 256'(idle_H), 256'(occ == 0));
      check_output("tri_count", 256'(triCount_U), 256'(exp_stat(model_tri)));
      check_output("stall_count", 256'(stallCount_U), 256'(exp_stat(model_stall)));
      if (validTri_R10H && occ > 0) begin
        check_output("tri_data", 256'(tri_R10S), 256'(sb[0].t));
        check_output("color_data", 256'(color_R10U), 256'(sb[0].c));
      end
      if (validTri_R10H && halt_RnnnnL) begin
        if (occ > 0) void'(sb.pop_front());
        model_tri++;
      end
      if (validTri_R10H && !halt_RnnnnL) model_stall++;
    end
  end

  initial begin
    ent_t a;
    #2;
    check_reset_values("por");
    @(posedge clk);
    #1 rst = 1'b1;

    // Single triangle through an empty block.
    for (int v = 0; v < VERTS; v++)
      for (int x = 0; x < AXIS; x++)
        a.t[v][x] = 24'h000100;
    for (int c = 0; c < COLORS; c++)
      a.c[c] = 24'h0000FF;
    apply_stimulus(1'b1, 1'b1, a);
    apply_stimulus(1'b0, 1'b1, a);
    apply_stimulus(1'b0, 1'b1, a);
    check_output("a_idle_back", 256'(idle_H), 256'(1'b1));

    // Full stall: six pushes, five fit.
    accepted = 0;
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b0, rand_ent());
    apply_stimulus(1'b0, 1'b0, rand_ent());
    apply_stimulus(1'b0, 1'b0, rand_ent());
    check_output("full_accepted", 256'(accepted), 256'(5));
    check_output("full_ready_low", 256'(in_ready_H), 256'(1'b0));

    // Release and drain in order.
    drain("release");
    check_output("release_tricnt", 256'(triCount_U), 256'(exp_stat(6)));

    // Continuous push with alternating halt.
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, (i % 2) == 0, rand_ent());
    drain("toggle");

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      apply_stimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), rand_ent());
    drain("random");

    // Asynchronous reset in the middle of a stall with three triangles buffered.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, rand_ent());
    apply_stimulus(1'b0, 1'b0, rand_ent());
    @(posedge clk);
    #1;
    if (pend) sb.push_back(pend_e);
    pend = 1'b0;
    #1 rst = 1'b0;
    #1;
    check_reset_values("midrst");
    sb.delete();
    model_tri   = 0;
    model_stall = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    check_output("post_rst_idle", 256'(idle_H), 256'(1'b1));
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b1, rand_ent());
    drain("post_rst");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
